// File: rtl/pt_write_buffer.sv
// =============================================================================
// Module      : pt_write_buffer
// Description : FIFO between projective_transform and memory_interface. It
//               turns (x, y) into a linear ZBT address, selects the frame bank
//               and issues hold-until-ack writes. Optional define PT_CLIP_EN
//               discards off-screen pixels at the input.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pt_write_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_flag,
  input  logic [17:0] pt_pixel_write,
  input  logic [9:0]  pt_x,
  input  logic [8:0]  pt_y,
  input  logic        pt_wr,
  output logic        ptflag,
  output logic [19:0] mem_addr,
  output logic [17:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        overflow
);

  localparam int              c_AW     = $clog2(DEPTH);
  localparam int              c_CW     = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL   = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_THRESH = c_CW'(DEPTH - 2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Entry layout: {bank, y[8:0], x[9:0], pixel[17:0]}
  logic [37:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_bank;
  logic            r_ptflag;
  logic            r_overflow;
  logic [19:0]     r_mem_addr;
  logic [17:0]     r_mem_data;
  logic [0:0]      r_state;
  logic [0:0]      w_state_next;

  logic            w_in_range;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [c_CW-1:0] w_count_next;
  logic [37:0]     w_head;
  logic [8:0]      w_head_y;
  logic [9:0]      w_head_x;
  logic [18:0]     w_head_lin;

`ifdef PT_CLIP_EN
  assign w_in_range = (pt_x < 10'd640) && (pt_y < 9'd480);
`else
  assign w_in_range = 1'b1;
`endif

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = pt_wr && w_in_range && !w_full;
  // Pop also serves as the output-register load strobe.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || mem_ack);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CW'(1);
      2'b01:   w_count_next = r_count - c_CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  assign w_head     = r_mem[r_rptr];
  assign w_head_y   = w_head[36:28];
  assign w_head_x   = w_head[27:18];
  // y*640 + x as two shifts and an add, wrapping at 19 bits
  assign w_head_lin = ({10'd0, w_head_y} << 9) + ({10'd0, w_head_y} << 7)
                    + {9'd0, w_head_x};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_bank, pt_y, pt_x, pt_pixel_write};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_bank     <= 1'b0;
      r_ptflag   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      r_count  <= w_count_next;
      r_ptflag <= (w_count_next <= c_THRESH);
      if (frame_flag) r_bank <= ~r_bank;
      if (pt_wr && w_in_range && w_full) r_overflow <= 1'b1;
    end
  end

  // Output state machine: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output state machine: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_next = S_BUSY;
      S_BUSY:  if (mem_ack) w_state_next = w_pop ? S_BUSY : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output state machine: outputs
  always_comb begin
    mem_we = (r_state == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_pop) begin
      r_mem_addr <= {w_head[37], w_head_lin};
      r_mem_data <= w_head[17:0];
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign ptflag   = r_ptflag;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pt_write_buffer.sv
// =============================================================================
// Module      : tb_pt_write_buffer
// Description : Scoreboard bench for pt_write_buffer (DEPTH = 8).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pt_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_flag;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        ptflag;
  logic [19:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_we;
  logic        mem_ack;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [37:0] sb_q[$];
  logic        bank_m   = 1'b0;
  bit          watch_ptflag = 0;
  bit          hold_pending = 0;
  logic [19:0] hold_addr;
  logic [17:0] hold_data;

  pt_write_buffer #(.DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_flag     (frame_flag),
    .pt_pixel_write (pt_pixel_write),
    .pt_x           (pt_x),
    .pt_y           (pt_y),
    .pt_wr          (pt_wr),
    .ptflag         (ptflag),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_ack        (mem_ack),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk_exp(input int x, input int y, input logic [17:0] d);
    logic [18:0] a;
    a = 19'(y * 640 + x);
    return {bank_m, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_px(input int x, input int y, input logic [17:0] d,
                        input logic ff, input bit exp_acc);
    pt_x = 10'(x);
    pt_y = 9'(y);
    pt_pixel_write = d;
    frame_flag = ff;
    pt_wr = 1'b1;
    if (exp_acc) sb_q.push_back(mk_exp(x, y, d));
    if (ff) bank_m = ~bank_m;
    tick();
    frame_flag = 1'b0;
  endtask

  task automatic idle_in();
    pt_wr = 1'b0;
    frame_flag = 1'b0;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (sb_q.size() != 0) check_value("drain_timeout", sb_q.size(), 0);
  endtask

  // Scoreboard / protocol monitor, mid-cycle
  always @(negedge clk) begin
    logic [37:0] e;
    if (reset) begin
      hold_pending = 0;
    end else begin
      if (hold_pending && mem_we) begin
        check_value("hold_addr", mem_addr, hold_addr);
        check_value("hold_data", mem_data, hold_data);
      end
      if (watch_ptflag) check_value("ptflag_cont", ptflag, 1);
      if (mem_we && mem_ack) begin
        check_value("write_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_value("wr_addr", mem_addr, e[37:18]);
          check_value("wr_data", mem_data, e[17:0]);
        end
        n_writes++;
      end
      hold_pending = mem_we && !mem_ack;
      hold_addr    = mem_addr;
      hold_data    = mem_data;
    end
  end

  initial begin
    int cyc;
    int w0;
    reset = 1'b1;
    mem_ack = 1'b0;
    idle_in();
    pt_x = '0;
    pt_y = '0;
    pt_pixel_write = '0;
    repeat (3) tick();
    check_value("rst_mem_we", mem_we, 0);
    check_value("rst_mem_addr", mem_addr, 0);
    check_value("rst_mem_data", mem_data, 0);
    check_value("rst_overflow", overflow, 0);
    check_value("rst_ptflag", ptflag, 0);
    reset = 1'b0;
    tick();
    check_value("ptflag_after_rst", ptflag, 1);

    // Single pixel latency
    mem_ack = 1'b1;
    put_px(5, 2, 18'h2A5A, 1'b0, 1'b1);
    idle_in();
    check_value("lat_e0_we", mem_we, 0);
    tick();
    check_value("lat_e1_we", mem_we, 1);
    check_value("lat_e1_addr", mem_addr, 20'd1285);
    check_value("lat_e1_data", mem_data, 18'h2A5A);
    tick();
    check_value("lat_e2_we", mem_we, 0);

    // Stall: output register + 8 FIFO entries, 10th push overflows
    mem_ack = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      put_px(k * 10, 3, 18'(k * 1000 + 7), 1'b0, k <= 9);
      check_value("stall_ptflag", ptflag, (k <= 7) ? 1 : 0);
      check_value("stall_overflow", overflow, (k == 10) ? 1 : 0);
    end
    idle_in();
    repeat (3) tick();
    check_value("stall_head_we", mem_we, 1);
    check_value("stall_head_addr", mem_addr, 20'd1930);
    mem_ack = 1'b1;
    w0 = n_writes;
    wait_drain(cyc);
    check_value("drain_cycles", cyc, 9);
    check_value("drain_writes", n_writes - w0, 9);
    tick();
    check_value("ovf_sticky", overflow, 1);

    // Reset mid-transfer with 3 queued
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) put_px(k, 7, 18'(k + 100), 1'b0, 1'b1);
    idle_in();
    tick();
    check_value("pre_rst_we", mem_we, 1);
    reset = 1'b1;
    tick();
    check_value("midrst_we", mem_we, 0);
    check_value("midrst_ptflag", ptflag, 0);
    check_value("midrst_overflow", overflow, 0);
    check_value("midrst_addr", mem_addr, 0);
    sb_q.delete();
    bank_m = 1'b0;
    reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    check_value("postrst_ptflag", ptflag, 1);
    w0 = n_writes;
    repeat (4) tick();
    check_value("postrst_no_write", n_writes - w0, 0);
    check_value("postrst_we", mem_we, 0);

    // Bank toggle coincident with a push
    put_px(0, 0, 18'h00011, 1'b1, 1'b1);
    put_px(1, 0, 18'h00022, 1'b0, 1'b1);
    idle_in();
    wait_drain(cyc);
    tick();

    // Continuous streaming, 100 pixels with ack held high
    watch_ptflag = 1;
    w0 = n_writes;
    for (int i = 0; i < 100; i++)
      put_px((i * 6) % 640, (i * 4) % 480, 18'($urandom), 1'b0, 1'b1);
    idle_in();
    wait_drain(cyc);
    watch_ptflag = 0;
    check_value("stream_writes", n_writes - w0, 100);
    tick();

    // Out-of-range coordinates
    w0 = n_writes;
`ifdef PT_CLIP_EN
    put_px(700, 10, 18'h3C3C3, 1'b0, 1'b0);
    idle_in();
    repeat (4) tick();
    check_value("clip_writes", n_writes - w0, 0);
`else
    put_px(700, 10, 18'h3C3C3, 1'b0, 1'b1);
    idle_in();
    wait_drain(cyc);
    tick();
    check_value("noclip_writes", n_writes - w0, 1);
`endif
    check_value("oor_overflow", overflow, 0);
    check_value("final_we", mem_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
